// File: rtl/demux_seq_driver.sv
// Serialises 8-bit words onto a 1-to-8 demux (din/sel), with a one-word hold buffer and optional inter-frame gap.
// Build option: define DEMUX_SEQ_MSB_FIRST_EN to walk lanes 7..0 instead of 0..7.
//
// state | meaning
// IDLE  | no frame in flight, hold empty
// SHIFT | driving one lane per cycle, bit_cnt = position within frame
// GAP   | idle spacing after a frame, gap_cnt counts down to zero
module demux_seq_driver #(
   parameter int GAP_CYCLES = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       din,
   output logic [2:0] sel,
   output logic       out_valid,
   output logic       frame_start,
   output logic       frame_done,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   localparam bit         HAS_GAP  = (GAP_CYCLES > 0);
   localparam logic [3:0] GAP_LOAD = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

   state_t     state, state_n;
   logic [2:0] bit_cnt, bit_cnt_n;
   logic [7:0] shift_reg, shift_reg_n;
   logic [3:0] gap_cnt, gap_cnt_n;
   logic [7:0] hold_reg, hold_reg_n;
   logic       hold_full, hold_full_n;
   logic       accept;
   logic [2:0] lane;

   assign in_ready = ~hold_full;
   assign accept   = in_valid & ~hold_full;

`ifdef DEMUX_SEQ_MSB_FIRST_EN
   assign lane = ~bit_cnt;
`else
   assign lane = bit_cnt;
`endif

   assign out_valid   = (state == SHIFT);
   assign din         = out_valid ? shift_reg[lane] : 1'b0;
   assign sel         = out_valid ? lane : 3'd0;
   assign frame_start = out_valid && (bit_cnt == 3'd0);
   assign frame_done  = out_valid && (bit_cnt == 3'd7);
   assign busy        = (state != IDLE) || hold_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bit_cnt   <= 3'd0;
         shift_reg <= 8'd0;
         gap_cnt   <= 4'd0;
         hold_reg  <= 8'd0;
         hold_full <= 1'b0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         shift_reg <= shift_reg_n;
         gap_cnt   <= gap_cnt_n;
         hold_reg  <= hold_reg_n;
         hold_full <= hold_full_n;
      end
   end

   always_comb begin
      state_n     = state;
      bit_cnt_n   = bit_cnt;
      shift_reg_n = shift_reg;
      gap_cnt_n   = gap_cnt;
      hold_reg_n  = hold_reg;
      hold_full_n = hold_full;

      case (state)
         IDLE: begin
            if (accept) begin
               state_n     = SHIFT;
               shift_reg_n = in_data;
               bit_cnt_n   = 3'd0;
            end
         end

         SHIFT: begin
            bit_cnt_n = bit_cnt + 3'd1;
            if (accept) begin
               hold_reg_n  = in_data;
               hold_full_n = 1'b1;
            end
            if (bit_cnt == 3'd7) begin
               if (HAS_GAP) begin
                  state_n   = GAP;
                  gap_cnt_n = GAP_LOAD;
               end else if (hold_full) begin
                  shift_reg_n = hold_reg;
                  hold_full_n = 1'b0;
               end else if (accept) begin
                  // word arriving on the last bit skips the hold and starts next cycle
                  shift_reg_n = in_data;
                  hold_full_n = 1'b0;
               end else begin
                  state_n = IDLE;
               end
            end
         end

         GAP: begin
            gap_cnt_n = gap_cnt - 4'd1;
            if (accept) begin
               hold_reg_n  = in_data;
               hold_full_n = 1'b1;
            end
            if (gap_cnt == 4'd0) begin
               bit_cnt_n = 3'd0;
               if (hold_full) begin
                  state_n     = SHIFT;
                  shift_reg_n = hold_reg;
                  hold_full_n = 1'b0;
               end else if (accept) begin
                  state_n     = SHIFT;
                  shift_reg_n = in_data;
                  hold_full_n = 1'b0;
               end else begin
                  state_n = IDLE;
               end
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_demux_seq_driver.sv
// Bench for demux_seq_driver: one instance with no gap, one with a 3-cycle gap, checked against a bit-stream scoreboard.
module tb_demux_seq_driver;

`ifdef DEMUX_SEQ_MSB_FIRST_EN
   localparam bit MSB = 1'b1;
`else
   localparam bit MSB = 1'b0;
`endif

   typedef struct {
      logic [2:0] sel;
      logic       din;
      logic       fs;
      logic       fd;
   } exp_t;

   typedef struct {
      logic       iv;
      logic [7:0] data;
      logic       ov;
      logic [2:0] sel;
      logic       din;
      logic       fs;
      logic       fd;
      logic       busy;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       iv [2];
   logic [7:0] idata [2];
   logic       rdy [2];
   logic       dn [2];
   logic [2:0] sl [2];
   logic       ov [2];
   logic       fs [2];
   logic       fd [2];
   logic       bsy [2];

   exp_t q [2][$];
   int   quiet [2];
   int   errors = 0;
   int   checks = 0;
   vec_t tbl [9];

   always #5 clk = ~clk;

   demux_seq_driver #(.GAP_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_data(idata[0]), .in_ready(rdy[0]),
      .din(dn[0]), .sel(sl[0]), .out_valid(ov[0]), .frame_start(fs[0]), .frame_done(fd[0]), .busy(bsy[0])
   );

   demux_seq_driver #(.GAP_CYCLES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_data(idata[1]), .in_ready(rdy[1]),
      .din(dn[1]), .sel(sl[1]), .out_valid(ov[1]), .frame_start(fs[1]), .frame_done(fd[1]), .busy(bsy[1])
   );

   function automatic logic [2:0] lane(input int i);
      return MSB ? 3'(7 - i) : 3'(i);
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push_word(input int k, input logic [7:0] w);
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         e.sel = lane(i);
         e.din = w[e.sel];
         e.fs  = (i == 0);
         e.fd  = (i == 7);
         q[k].push_back(e);
      end
   endtask

   // Reference: each accepted word yields 8 lane bits in order; between frames only the fixed gap may be idle.
   task automatic mon(input int k);
      exp_t e;
      int   sz;
      int   held;
      sz   = q[k].size();
      held = ov[k] ? ((sz > 0) ? (sz - 1) / 8 : 0) : sz / 8;
      chk($sformatf("in_ready[%0d]", k), 16'(rdy[k]), 16'(held == 0));
      if (ov[k]) begin
         chk($sformatf("gap_short[%0d]", k), 16'(quiet[k]), 16'd0);
         quiet[k] = 0;
         chk($sformatf("busy_active[%0d]", k), 16'(bsy[k]), 16'd1);
         if (sz == 0) begin
            chk($sformatf("spurious_out[%0d]", k), 16'(ov[k]), 16'd0);
         end else begin
            e = q[k].pop_front();
            chk($sformatf("sel[%0d]", k), 16'(sl[k]), 16'(e.sel));
            chk($sformatf("din[%0d]", k), 16'(dn[k]), 16'(e.din));
            chk($sformatf("frame_start[%0d]", k), 16'(fs[k]), 16'(e.fs));
            chk($sformatf("frame_done[%0d]", k), 16'(fd[k]), 16'(e.fd));
            if (e.fd) quiet[k] = (k == 1) ? 3 : 0;
         end
      end else begin
         chk($sformatf("idle_outs[%0d]", k), {12'd0, dn[k], sl[k]}, 16'd0);
         chk($sformatf("idle_flags[%0d]", k), {14'd0, fs[k], fd[k]}, 16'd0);
         if (quiet[k] > 0) begin
            chk($sformatf("busy_gap[%0d]", k), 16'(bsy[k]), 16'd1);
            quiet[k]--;
         end else begin
            chk($sformatf("bubble[%0d]", k), 16'(sz), 16'd0);
            if (sz == 0) chk($sformatf("busy_idle[%0d]", k), 16'(bsy[k]), 16'd0);
         end
      end
   endtask

   task automatic tick();
      for (int k = 0; k < 2; k++)
         if (iv[k] && rdy[k]) push_word(k, idata[k]);
      @(posedge clk);
      @(negedge clk);
      mon(0);
      mon(1);
   endtask

   task automatic check_all_zero(input string nm);
      for (int k = 0; k < 2; k++) begin
         chk({nm, "_outs"}, {9'd0, ov[k], dn[k], sl[k], fs[k], fd[k], bsy[k]}, 16'd0);
         chk({nm, "_ready"}, 16'(rdy[k]), 16'd1);
      end
   endtask

   initial begin
      int n;
      int gaps;

      tbl[0] = '{1'b1, 8'hA5, 1'b1, lane(0), 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[1] = '{1'b0, 8'h00, 1'b1, lane(1), 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[2] = '{1'b0, 8'h00, 1'b1, lane(2), 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{1'b0, 8'h00, 1'b1, lane(3), 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{1'b0, 8'h00, 1'b1, lane(4), 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{1'b0, 8'h00, 1'b1, lane(5), 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[6] = '{1'b0, 8'h00, 1'b1, lane(6), 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[7] = '{1'b0, 8'h00, 1'b1, lane(7), 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[8] = '{1'b0, 8'h00, 1'b0, 3'd0,    1'b0, 1'b0, 1'b0, 1'b0};

      for (int k = 0; k < 2; k++) begin
         iv[k] = 1'b0;
         idata[k] = 8'h00;
         quiet[k] = 0;
      end

      // reset state
      @(negedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // single word 8'hA5 from IDLE
      for (int i = 0; i < 9; i++) begin
         iv[0] = tbl[i].iv;
         idata[0] = tbl[i].data;
         tick();
         chk("a5_valid", 16'(ov[0]), 16'(tbl[i].ov));
         chk("a5_sel", 16'(sl[0]), 16'(tbl[i].sel));
         chk("a5_din", 16'(dn[0]), 16'(tbl[i].din));
         chk("a5_start", 16'(fs[0]), 16'(tbl[i].fs));
         chk("a5_done", 16'(fd[0]), 16'(tbl[i].fd));
         chk("a5_busy", 16'(bsy[0]), 16'(tbl[i].busy));
      end

      // back-to-back 0F, F0 with in_valid held and data wiggling while stalled
      iv[0] = 1'b1;
      idata[0] = 8'h0F;
      tick();
      chk("b2b_first_start", 16'(fs[0]), 16'd1);
      chk("b2b_first_ready", 16'(rdy[0]), 16'd1);
      idata[0] = 8'hF0;
      tick();
      for (n = 2; n <= 16; n++) begin
         chk("b2b_valid", 16'(ov[0]), 16'd1);
         if (n <= 8) chk("b2b_ready_low", 16'(rdy[0]), 16'd0);
         if (n == 9) begin
            chk("b2b_ready_back", 16'(rdy[0]), 16'd1);
            chk("b2b_second_start", 16'(fs[0]), 16'd1);
         end
         if (n < 8) idata[0] = 8'($urandom);
         else iv[0] = 1'b0;
         if (n < 16) tick();
      end
      chk("b2b_second_done", 16'(fd[0]), 16'd1);
      tick();
      chk("b2b_end_idle", 16'(ov[0]), 16'd0);

      // 3-cycle gap between two frames
      iv[1] = 1'b1;
      idata[1] = 8'h3C;
      tick();
      idata[1] = 8'hC3;
      tick();
      iv[1] = 1'b0;
      n = 0;
      while (!fd[1] && n < 40) begin
         tick();
         n++;
      end
      chk("gap3_done_seen", 16'(fd[1]), 16'd1);
      gaps = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ov[1]) break;
         gaps++;
      end
      chk("gap3_len", 16'(gaps), 16'd3);
      chk("gap3_start", 16'(fs[1]), 16'd1);
      for (int i = 0; i < 12; i++) tick();

      // reset mid-frame with a held word
      iv[0] = 1'b1;
      idata[0] = 8'hFF;
      tick();
      idata[0] = 8'h5A;
      tick();
      iv[0] = 1'b0;
      n = 0;
      while (sl[0] != 3'd4 && n < 12) begin
         tick();
         n++;
      end
      chk("rst_at_sel4", 16'(sl[0]), 16'd4);
      chk("rst_held", 16'(rdy[0]), 16'd0);
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_mid");
      for (int k = 0; k < 2; k++) begin
         q[k].delete();
         quiet[k] = 0;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("post_rst_quiet", {14'd0, ov[0], fd[0]}, 16'd0);
      end

      // 8'h81 lane order end-points
      iv[0] = 1'b1;
      idata[0] = 8'h81;
      tick();
      iv[0] = 1'b0;
      chk("x81_first_sel", 16'(sl[0]), 16'(lane(0)));
      chk("x81_first_din", 16'(dn[0]), 16'd1);
      chk("x81_start", 16'(fs[0]), 16'd1);
      for (int i = 0; i < 7; i++) tick();
      chk("x81_last_sel", 16'(sl[0]), 16'(lane(7)));
      chk("x81_last_din", 16'(dn[0]), 16'd1);
      chk("x81_done", 16'(fd[0]), 16'd1);
      tick();

      // random traffic on both instances
      for (int c = 0; c < 1500; c++) begin
         for (int k = 0; k < 2; k++) begin
            iv[k] = ($urandom_range(0, 2) != 0);
            idata[k] = 8'($urandom);
         end
         tick();
      end
      iv[0] = 1'b0;
      iv[1] = 1'b0;
      for (int i = 0; i < 40; i++) tick();
      chk("drain0", 16'(q[0].size()), 16'd0);
      chk("drain1", 16'(q[1].size()), 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/demux_seq_driver.md
DEMUX_SEQ_DRIVER -- requirements
Module: demux_seq_driver

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 0, giving the number of idle cycles inserted after each frame (legal range 0..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: upstream word available.
REQ-005 The block SHALL have port in_data, input, 8 bits: word to distribute, one bit per lane.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept a word; a transfer occurs in a cycle where in_valid and in_ready are both 1.
REQ-007 The block SHALL have port din, output, 1 bit: serial bit for the downstream 1-to-8 demux data input.
REQ-008 The block SHALL have port sel, output, 3 bits: lane index for the downstream demux select.
REQ-009 The block SHALL have port out_valid, output, 1 bit: din/sel carry a live bit this cycle.
REQ-010 The block SHALL have port frame_start, output, 1 bit: first bit of a frame.
REQ-011 The block SHALL have port frame_done, output, 1 bit: last bit of a frame.
REQ-012 The block SHALL have port busy, output, 1 bit: FSM not in IDLE or hold register occupied.

Function
REQ-013 The block SHALL hold three FSM states (IDLE, SHIFT, GAP), a 3-bit bit counter, an 8-bit shift register, a 4-bit gap counter, and a one-entry hold register with a full flag.
REQ-014 in_ready SHALL equal the inverse of the hold-full flag, combinationally.
REQ-015 A word accepted in IDLE SHALL load the shift register directly, and the FSM SHALL be in SHIFT with out_valid=1 and sel at the first index in the next cycle (1-cycle latency).
REQ-016 A word accepted in SHIFT or GAP SHALL be written to the hold register and set hold-full.
REQ-017 In SHIFT, the block SHALL output one bit per cycle for exactly 8 cycles: din = shift_reg[sel], with sel stepping by one each cycle.
REQ-018 frame_start SHALL be 1 only on the first SHIFT cycle of a frame, and frame_done SHALL be 1 only on the eighth.
REQ-019 After the eighth bit with GAP_CYCLES=0 and hold full, the block SHALL start the next frame in the immediately following cycle, moving hold to the shift register and clearing hold-full at that edge (no bubble).
REQ-020 After the eighth bit with GAP_CYCLES>0, the block SHALL enter GAP for exactly GAP_CYCLES cycles and then start the held frame, or go to IDLE if hold is empty.
REQ-021 After the eighth bit with GAP_CYCLES=0 and hold empty, the block SHALL enter IDLE.
REQ-022 When out_valid=0, din and sel SHALL both be driven 0.
REQ-023 in_valid while in_ready=0 SHALL be ignored, and in_data SHALL NOT be sampled.
REQ-024 Bits shall not be dropped, duplicated, or reordered across back-to-back frames.

Reset
REQ-025 Asserting rst_n low SHALL immediately force FSM=IDLE, counters=0, hold-full=0, and out_valid, din, sel, frame_start, frame_done, busy=0; in_ready SHALL read 1.
REQ-026 Reset asserted mid-frame SHALL abandon the frame and any held word, and after release no partial frame or frame_done SHALL appear.

Configuration
REQ-027 With macro DEMUX_SEQ_MSB_FIRST_EN defined, sel SHALL run 7,6,...,0 within a frame; undefined, it SHALL run 0,1,...,7. In both cases din = in_data[sel], so each lane receives the same bit either way.

Verification
REQ-028 Bench: reset, then accept 8'hA5 in IDLE -> next cycle frame_start=1, sel 0..7 over 8 cycles, din sequence 1,0,1,0,0,1,0,1, frame_done on sel=7, then IDLE with busy=0.
REQ-029 Bench: with GAP_CYCLES=0, send 8'h0F then 8'hF0 back-to-back with in_valid held -> 16 consecutive out_valid cycles, in_ready low from the cycle after the second accept until the second frame begins.
REQ-030 Bench: with GAP_CYCLES=3, send two words -> exactly 3 cycles of out_valid=0 between frame_done and the next frame_start.
REQ-031 Bench: assert rst_n low at sel=4 of 8'hFF with a held word -> all outputs 0 immediately; after release, no output until a new accept.
REQ-032 Bench: define DEMUX_SEQ_MSB_FIRST_EN and send 8'h81 -> sel 7..0, din 1,0,0,0,0,0,0,1; frame_start at sel=7 and frame_done at sel=0.
REQ-033 Bench: hold in_valid=1 while in_ready=0 and change in_data -> only values present on accept cycles ever appear on din.
